// File: rtl/apb_pkg.sv
// Shared types and widths for the APB completer and its register file.
// Also holds the byte-lane merge used by the storage write port.
package apb_pkg;

   localparam int APB_DATA_W = 32;
   localparam int APB_ADDR_W = 32;
   localparam int APB_STRB_W = 4;

   typedef enum logic {APB_IDLE, APB_ACCESS} apb_state_e;

   // Lanes with a clear strobe keep the old byte.
   function automatic logic [APB_DATA_W-1:0] apply_strobes(
      input logic [APB_DATA_W-1:0] old_word,
      input logic [APB_DATA_W-1:0] new_word,
      input logic [APB_STRB_W-1:0] strb
   );
      logic [APB_DATA_W-1:0] merged;
      merged = old_word;
      for (int b = 0; b < APB_STRB_W; b++) begin
         if (strb[b]) begin
            merged[b*8 +: 8] = new_word[b*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x 32-bit word storage with async clear, a byte-enable write port
// and a combinational read port.
module apb_slv_regfile
   import apb_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [APB_STRB_W-1:0] wr_strb,
   input  logic [APB_DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [APB_DATA_W-1:0] rd_data
);

   logic [APB_DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wr_idx] <= apply_strobes(mem[wr_idx], wr_data, wr_strb);
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer in front of a small word-addressed memory, with fixed wait
// states and error response. Define APB_SLV_PSTRB_EN to add byte strobes.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int              DEPTH       = 16,
   parameter int              WAIT_CYCLES = 2,
   parameter logic [31:0]     BASE_ADDR   = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic [APB_ADDR_W-1:0] paddr_i,
   input  logic                  pwrite_i,
   input  logic [APB_DATA_W-1:0] pwdata_i,
`ifdef APB_SLV_PSTRB_EN
   input  logic [APB_STRB_W-1:0] pstrb_i,
`endif
   output logic                  pready_o,
   output logic [APB_DATA_W-1:0] prdata_o,
   output logic                  pslverr_o
);

   localparam int IDX_W = $clog2(DEPTH);

   apb_state_e            state, state_next;
   logic [3:0]            cnt, cnt_next;
   logic [APB_ADDR_W-1:0] offset;
   logic [IDX_W-1:0]      word_idx;
   logic                  addr_err;
   logic                  xfer_err;
   logic                  mem_we;
   logic [APB_STRB_W-1:0] wr_strb;
   logic [APB_DATA_W-1:0] rd_word;

   // An address below BASE_ADDR wraps to a huge offset, so the upper-bit
   // test catches both ends of the window.
   assign offset   = paddr_i - BASE_ADDR;
   assign word_idx = offset[IDX_W+1:2];
   assign addr_err = (offset[1:0] != 2'b00) ||
                     (offset[APB_ADDR_W-1:IDX_W+2] != '0);

`ifdef APB_SLV_PSTRB_EN
   assign xfer_err = addr_err || (!pwrite_i && (pstrb_i != '0));
   assign wr_strb  = pstrb_i;
`else
   assign xfer_err = addr_err;
   assign wr_strb  = '1;
`endif

   assign pready_o  = (state == APB_ACCESS) && (cnt == 4'd0) && psel_i && penable_i;
   assign pslverr_o = pready_o && xfer_err;
   assign prdata_o  = (pready_o && !pwrite_i && !xfer_err) ? rd_word : '0;
   assign mem_we    = pready_o && pwrite_i && !xfer_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= APB_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Dropping psel mid-access abandons the transfer without a response.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         APB_IDLE: begin
            if (psel_i && !penable_i) begin
               state_next = APB_ACCESS;
               cnt_next   = 4'(WAIT_CYCLES);
            end
         end
         APB_ACCESS: begin
            if (!psel_i) begin
               state_next = APB_IDLE;
               cnt_next   = 4'd0;
            end else if (cnt != 4'd0) begin
               cnt_next = cnt - 4'd1;
            end else if (penable_i) begin
               state_next = APB_IDLE;
            end
         end
         default: begin
            state_next = APB_IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   apb_slv_regfile #(
      .DEPTH(DEPTH)
   ) u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (mem_we),
      .wr_idx  (word_idx),
      .wr_strb (wr_strb),
      .wr_data (pwdata_i),
      .rd_idx  (word_idx),
      .rd_data (rd_word)
   );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance sharing the bus except for their selects.
module tb_apb_slave_mem;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        psel_w, psel_z, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        pready_w, pslverr_w, pready_z, pslverr_z;
   logic [31:0] prdata_w, prdata_z;
`ifdef APB_SLV_PSTRB_EN
   logic [3:0]  pstrb;
   logic [3:0]  wrStrb;
   logic [3:0]  rdStrb;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_w (
      .clk       (clk),
      .reset_n   (reset_n),
      .psel_i    (psel_w),
      .penable_i (penable),
      .paddr_i   (paddr),
      .pwrite_i  (pwrite),
      .pwdata_i  (pwdata),
`ifdef APB_SLV_PSTRB_EN
      .pstrb_i   (pstrb),
`endif
      .pready_o  (pready_w),
      .prdata_o  (prdata_w),
      .pslverr_o (pslverr_w)
   );

   apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_z (
      .clk       (clk),
      .reset_n   (reset_n),
      .psel_i    (psel_z),
      .penable_i (penable),
      .paddr_i   (paddr),
      .pwrite_i  (pwrite),
      .pwdata_i  (pwdata),
`ifdef APB_SLV_PSTRB_EN
      .pstrb_i   (pstrb),
`endif
      .pready_o  (pready_z),
      .prdata_o  (prdata_z),
      .pslverr_o (pslverr_z)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic setBus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
      paddr  = addr;
      pwrite = wr;
      pwdata = wdata;
`ifdef APB_SLV_PSTRB_EN
      pstrb  = wr ? wrStrb : rdStrb;
`endif
   endtask

   // One full transfer; latency counts cycles from SETUP to pready, left at 0 if pready never rises.
   task automatic applyStimulus(input bit toZero, input logic [31:0] addr, input logic wr,
                                input logic [31:0] wdata, output logic [31:0] rdata,
                                output logic err, output int latency);
      @(negedge clk);
      if (toZero) psel_z = 1'b1;
      else        psel_w = 1'b1;
      penable = 1'b0;
      setBus(addr, wr, wdata);
      latency = 0;
      rdata   = '0;
      err     = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         #1;
         if (toZero ? pready_z : pready_w) begin
            latency = cyc;
            rdata   = toZero ? prdata_z : prdata_w;
            err     = toZero ? pslverr_z : pslverr_w;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic applyIdle();
      @(negedge clk);
      psel_w  = 1'b0;
      psel_z  = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rdata;
      logic        err;
      int          lat;

      reset_n = 1'b0;
      psel_w  = 1'b0;
      psel_z  = 1'b0;
      penable = 1'b0;
      paddr   = '0;
      pwrite  = 1'b0;
      pwdata  = '0;
`ifdef APB_SLV_PSTRB_EN
      wrStrb  = 4'hF;
      rdStrb  = 4'h0;
      pstrb   = 4'h0;
`endif
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_pready", pready_w, 0);
      checkOutput("rst_prdata", prdata_w, 0);
      checkOutput("rst_pslverr", pslverr_w, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Wait-state write then read back
      applyStimulus(0, 32'h04, 1, 32'hDEAD_BEEF, rdata, err, lat);
      checkOutput("wr04_latency", lat, 3);
      checkOutput("wr04_err", err, 0);
      applyIdle();
      applyStimulus(0, 32'h04, 0, 32'h0, rdata, err, lat);
      checkOutput("rd04_latency", lat, 3);
      checkOutput("rd04_data", rdata, 32'hDEAD_BEEF);
      checkOutput("rd04_err", err, 0);
      applyIdle();

      // Zero-wait back-to-back write/read
      applyStimulus(1, 32'h3C, 1, 32'hCAFE_F00D, rdata, err, lat);
      checkOutput("z_wr3c_latency", lat, 1);
      checkOutput("z_wr3c_err", err, 0);
      applyStimulus(1, 32'h3C, 0, 32'h0, rdata, err, lat);
      checkOutput("z_rd3c_latency", lat, 1);
      checkOutput("z_rd3c_data", rdata, 32'hCAFE_F00D);
      applyIdle();

      // Error responses
      applyStimulus(0, 32'h40, 0, 32'h0, rdata, err, lat);
      checkOutput("rd40_latency", lat, 3);
      checkOutput("rd40_err", err, 1);
      checkOutput("rd40_data", rdata, 0);
      applyIdle();
      applyStimulus(0, 32'h06, 0, 32'h0, rdata, err, lat);
      checkOutput("rd06_err", err, 1);
      checkOutput("rd06_data", rdata, 0);
      applyIdle();
      applyStimulus(0, 32'h40, 1, 32'h55AA_55AA, rdata, err, lat);
      checkOutput("wr40_err", err, 1);
      applyIdle();
      applyStimulus(0, 32'h00, 0, 32'h0, rdata, err, lat);
      checkOutput("rd00_after_wr40", rdata, 0);
      applyIdle();

      // Abort a write while wait states remain
      applyStimulus(0, 32'h08, 1, 32'h1234_5678, rdata, err, lat);
      checkOutput("wr08_latency", lat, 3);
      applyIdle();
      @(negedge clk);
      psel_w  = 1'b1;
      penable = 1'b0;
      setBus(32'h08, 1, 32'hFFFF_FFFF);
      @(negedge clk);
      penable = 1'b1;
      #1;
      checkOutput("abort_access_rdy", pready_w, 0);
      @(negedge clk);
      psel_w  = 1'b0;
      penable = 1'b0;
      #1;
      checkOutput("abort_drop_rdy", pready_w, 0);
      applyStimulus(0, 32'h08, 0, 32'h0, rdata, err, lat);
      checkOutput("abort_rd08_latency", lat, 3);
      checkOutput("abort_rd08_data", rdata, 32'h1234_5678);
      applyIdle();

      // psel & penable without a SETUP phase
      @(negedge clk);
      psel_w  = 1'b1;
      penable = 1'b1;
      setBus(32'h04, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("no_setup_rdy", pready_w, 0);
         @(negedge clk);
      end
      psel_w  = 1'b0;
      penable = 1'b0;

      // Reset during ACCESS while a read is being answered
      @(negedge clk);
      psel_w  = 1'b1;
      penable = 1'b0;
      setBus(32'h04, 0, 32'h0);
      @(negedge clk);
      penable = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("pre_rst_rdy", pready_w, 1);
      checkOutput("pre_rst_data", prdata_w, 32'hDEAD_BEEF);
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_rdy", pready_w, 0);
      checkOutput("mid_rst_data", prdata_w, 0);
      checkOutput("mid_rst_err", pslverr_w, 0);
      @(negedge clk);
      reset_n = 1'b1;
      psel_w  = 1'b0;
      penable = 1'b0;
      applyStimulus(0, 32'h04, 0, 32'h0, rdata, err, lat);
      checkOutput("post_rst_rd04_latency", lat, 3);
      checkOutput("post_rst_rd04_data", rdata, 0);
      applyIdle();
      applyStimulus(0, 32'h08, 0, 32'h0, rdata, err, lat);
      checkOutput("post_rst_rd08_data", rdata, 0);
      applyIdle();
      applyStimulus(1, 32'h3C, 0, 32'h0, rdata, err, lat);
      checkOutput("post_rst_z_rd3c_data", rdata, 0);
      applyIdle();

`ifdef APB_SLV_PSTRB_EN
      // Byte-lane writes
      wrStrb = 4'hF;
      applyStimulus(0, 32'h00, 1, 32'h1122_3344, rdata, err, lat);
      checkOutput("strb_full_err", err, 0);
      applyIdle();
      wrStrb = 4'h5;
      applyStimulus(0, 32'h00, 1, 32'hAABB_CCDD, rdata, err, lat);
      checkOutput("strb_0101_err", err, 0);
      applyIdle();
      applyStimulus(0, 32'h00, 0, 32'h0, rdata, err, lat);
      checkOutput("strb_merge_data", rdata, 32'h11BB_33DD);
      applyIdle();
      wrStrb = 4'h0;
      applyStimulus(0, 32'h00, 1, 32'h0000_0000, rdata, err, lat);
      checkOutput("strb_none_err", err, 0);
      applyIdle();
      applyStimulus(0, 32'h00, 0, 32'h0, rdata, err, lat);
      checkOutput("strb_none_data", rdata, 32'h11BB_33DD);
      applyIdle();
      rdStrb = 4'h1;
      applyStimulus(0, 32'h00, 0, 32'h0, rdata, err, lat);
      checkOutput("rd_strb_err", err, 1);
      checkOutput("rd_strb_data", rdata, 0);
      applyIdle();
      rdStrb = 4'h0;
      wrStrb = 4'hF;
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
